// File: rtl/eq_pkg.sv
// Shared constants, state type and helpers for the equalizer mixer stages.
package eq_pkg;

    localparam int unsigned DEF_N_BANDS     = 10;
    localparam int unsigned DEF_AUDIO_WIDTH = 24;
    localparam int unsigned DEF_GAIN_WIDTH  = 8;
    localparam int unsigned DEF_GAIN_FRAC   = 5;

    typedef enum logic {IDLE, MAC} eq_state_e;

    function automatic int unsigned unity_gain(input int unsigned gain_frac);
        return 32'd1 << gain_frac;
    endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// Sample handshake, gain programming and status signals of the band mixer.
interface eq_band_mixer_if
    import eq_pkg::*;
#(
    parameter int unsigned N_BANDS     = DEF_N_BANDS,
    parameter int unsigned AUDIO_WIDTH = DEF_AUDIO_WIDTH,
    parameter int unsigned GAIN_WIDTH  = DEF_GAIN_WIDTH
);

    localparam int unsigned ADDR_WIDTH = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;

    logic                           in_valid;
    logic                           in_ready;
    logic [AUDIO_WIDTH-1:0]         audio_in;
    logic [N_BANDS*AUDIO_WIDTH-1:0] bands_in;
    logic                           bypass;
    logic                           gain_we;
    logic [ADDR_WIDTH-1:0]          gain_addr;
    logic [GAIN_WIDTH-1:0]          gain_wdata;
    logic                           out_valid;
    logic [AUDIO_WIDTH-1:0]         audio_out;
    logic                           sat_flag;
    logic                           sat_clr;

    modport master (
        output in_valid, audio_in, bands_in, bypass, gain_we, gain_addr, gain_wdata, sat_clr,
        input  in_ready, out_valid, audio_out, sat_flag
    );

    modport slave (
        input  in_valid, audio_in, bands_in, bypass, gain_we, gain_addr, gain_wdata, sat_clr,
        output in_ready, out_valid, audio_out, sat_flag
    );

endinterface

// File: rtl/eq_round_sat.sv
// Round-half-up, arithmetic right shift and clamp to a narrower signed range.
module eq_round_sat #(
    parameter int unsigned IN_WIDTH  = 36,
    parameter int unsigned OUT_WIDTH = 24,
    parameter int unsigned SHIFT     = 5
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << RND_POS) : '0;
    localparam logic signed [IN_WIDTH:0] MAX =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [IN_WIDTH:0] rounded;
    logic signed [IN_WIDTH:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the extremes.
    always_comb begin
        rounded = $signed({din[IN_WIDTH-1], din}) + RND;
        shifted = rounded >>> SHIFT;
        sat     = 1'b1;
        if (shifted > MAX) begin
            dout = MAX[OUT_WIDTH-1:0];
        end else if (shifted < MIN) begin
            dout = MIN[OUT_WIDTH-1:0];
        end else begin
            dout = shifted[OUT_WIDTH-1:0];
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Time-multiplexed band gain mixer: one shared MAC, N_BANDS cycles per sample.
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int unsigned N_BANDS     = DEF_N_BANDS,
    parameter int unsigned AUDIO_WIDTH = DEF_AUDIO_WIDTH,
    parameter int unsigned GAIN_WIDTH  = DEF_GAIN_WIDTH,
    parameter int unsigned GAIN_FRAC   = DEF_GAIN_FRAC
) (
    input logic            clk,
    input logic            rst_n,
    eq_band_mixer_if.slave bus
);

    localparam int unsigned IDX_WIDTH  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int unsigned PROD_WIDTH = AUDIO_WIDTH + GAIN_WIDTH;
    localparam int unsigned ACC_WIDTH  = PROD_WIDTH + $clog2(N_BANDS);
    localparam logic [GAIN_WIDTH-1:0] UNITY    = GAIN_WIDTH'(unity_gain(GAIN_FRAC));
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(N_BANDS - 1);

    eq_state_e                    state_q, state_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum;
    logic signed [PROD_WIDTH-1:0] prod;
    logic [GAIN_WIDTH-1:0]        pend_q [N_BANDS];
    logic [GAIN_WIDTH-1:0]        act_q  [N_BANDS];
    logic [AUDIO_WIDTH-1:0]       band_q [N_BANDS];
    logic [AUDIO_WIDTH-1:0]       dry_q;
    logic                         bypass_q;
    logic                         accept;
    logic                         finish;
    logic signed [AUDIO_WIDTH-1:0] mix_out;
    logic                         mix_sat;
    logic [AUDIO_WIDTH-1:0]       out_q;
    logic                         out_valid_q;
    logic                         sat_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.audio_out = out_q;
    assign bus.sat_flag  = sat_q;

    assign prod    = PROD_WIDTH'($signed(band_q[idx_q])) * PROD_WIDTH'($signed(act_q[idx_q]));
    assign acc_sum = acc_q + ACC_WIDTH'(prod);

    eq_round_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (AUDIO_WIDTH),
        .SHIFT     (GAIN_FRAC)
    ) u_round_sat (
        .din  (acc_sum),
        .dout (mix_out),
        .sat  (mix_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // Active bank copies the pre-write pending values, so a same-cycle write lands next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_BANDS); k++) begin
                pend_q[k] <= UNITY;
                act_q[k]  <= UNITY;
                band_q[k] <= '0;
            end
            dry_q    <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < int'(N_BANDS); k++) begin
                    act_q[k]  <= pend_q[k];
                    band_q[k] <= bus.bands_in[k*AUDIO_WIDTH +: AUDIO_WIDTH];
                end
                dry_q    <= bus.audio_in;
                bypass_q <= bus.bypass;
            end
            if (bus.gain_we && (32'(bus.gain_addr) < N_BANDS)) begin
                pend_q[bus.gain_addr] <= bus.gain_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= finish;
            if (finish) begin
                out_q <= bypass_q ? dry_q : mix_out;
            end
            if (finish && !bypass_q && mix_sat) begin
                sat_q <= 1'b1;
            end else if (bus.sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed and randomized checks of eq_band_mixer against an arithmetic reference model.
module tb_eq_band_mixer;

    localparam int NB = 10;
    localparam int AW = 24;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    int band_m [NB];
    int pend_m [NB];
    int act_m  [NB];
    bit sat_m;

    eq_band_mixer_if #(.N_BANDS(10), .AUDIO_WIDTH(24), .GAIN_WIDTH(8)) m_if ();
    eq_band_mixer_if #(.N_BANDS(3), .AUDIO_WIDTH(24), .GAIN_WIDTH(8)) s_if ();

    eq_band_mixer #(
        .N_BANDS     (10),
        .AUDIO_WIDTH (24),
        .GAIN_WIDTH  (8),
        .GAIN_FRAC   (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    eq_band_mixer #(
        .N_BANDS     (3),
        .AUDIO_WIDTH (24),
        .GAIN_WIDTH  (8),
        .GAIN_FRAC   (0)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Weighted sum, round half up, shift by 5, clamp to 24-bit signed.
    function automatic int mix_model(input bit byp, input int ain, output bit clamp);
        longint s;
        clamp = 1'b0;
        if (byp) return ain;
        s = 0;
        for (int k = 0; k < NB; k++) s += longint'(band_m[k]) * longint'(act_m[k]);
        s = (s + 16) >>> 5;
        if (s > 8388607) begin
            clamp = 1'b1;
            s = 8388607;
        end else if (s < -8388608) begin
            clamp = 1'b1;
            s = -8388608;
        end
        return int'(s);
    endfunction

    function automatic void model_write(input int addr, input int val);
        if (addr < NB) pend_m[addr] = val;
    endfunction

    task automatic write_gain(input int addr, input int val);
        @(negedge clk);
        m_if.gain_we    = 1'b1;
        m_if.gain_addr  = 4'(addr);
        m_if.gain_wdata = 8'(val);
        @(negedge clk);
        m_if.gain_we = 1'b0;
        model_write(addr, val);
    endtask

    task automatic run_sample(input string tag, input bit byp, input int ain,
                              input bit wr_now, input int wr_addr, input int wr_val,
                              input bit wr_mid, input int mid_addr, input int mid_val);
        int lat;
        int expv;
        bit clamp;
        @(negedge clk);
        chk({tag, ".ready"}, m_if.in_ready, 1);
        act_m = pend_m;
        expv  = mix_model(byp, ain, clamp);
        if (!byp && clamp) sat_m = 1'b1;
        m_if.in_valid = 1'b1;
        m_if.bypass   = byp;
        m_if.audio_in = 24'(ain);
        for (int k = 0; k < NB; k++) m_if.bands_in[k*AW +: AW] = 24'(band_m[k]);
        if (wr_now) begin
            m_if.gain_we    = 1'b1;
            m_if.gain_addr  = 4'(wr_addr);
            m_if.gain_wdata = 8'(wr_val);
            model_write(wr_addr, wr_val);
        end
        @(negedge clk);
        m_if.in_valid = 1'b0;
        m_if.gain_we  = 1'b0;
        lat = 0;
        while (!m_if.out_valid && lat < 40) begin
            if (wr_mid && lat == 3) begin
                m_if.gain_we    = 1'b1;
                m_if.gain_addr  = 4'(mid_addr);
                m_if.gain_wdata = 8'(mid_val);
                model_write(mid_addr, mid_val);
            end else begin
                m_if.gain_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        m_if.gain_we = 1'b0;
        chk({tag, ".latency"}, lat, 10);
        chk({tag, ".audio_out"}, $signed(m_if.audio_out), expv);
        chk({tag, ".sat_flag"}, m_if.sat_flag, sat_m);
        @(negedge clk);
        chk({tag, ".pulse"}, m_if.out_valid, 0);
    endtask

    initial begin
        int exp_q [$];
        int t_q [$];
        int n_acc;
        int n_out;
        int last_acc;
        int lat;
        int cnt;
        int expv;
        int t0;
        bit will_acc;
        int sb [3];
        int sg [3];

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        m_if.in_valid = 1'b0; m_if.audio_in = '0; m_if.bands_in = '0; m_if.bypass = 1'b0;
        m_if.gain_we = 1'b0; m_if.gain_addr = '0; m_if.gain_wdata = '0; m_if.sat_clr = 1'b0;
        s_if.in_valid = 1'b0; s_if.audio_in = '0; s_if.bands_in = '0; s_if.bypass = 1'b0;
        s_if.gain_we = 1'b0; s_if.gain_addr = '0; s_if.gain_wdata = '0; s_if.sat_clr = 1'b0;
        for (int k = 0; k < NB; k++) pend_m[k] = 32;
        sat_m = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset.in_ready", m_if.in_ready, 1);
        chk("reset.out_valid", m_if.out_valid, 0);
        chk("reset.audio_out", m_if.audio_out, 0);
        chk("reset.sat_flag", m_if.sat_flag, 0);
        rst_n = 1'b1;

        // Unity gains, all bands 1000 -> 10000
        for (int k = 0; k < NB; k++) band_m[k] = 1000;
        run_sample("unity", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("unity.value", $signed(m_if.audio_out), 10000);

        // Weighted: gain0 = 2.0, others muted; then a mid-MAC gain write
        write_gain(0, 64);
        for (int k = 1; k < NB; k++) write_gain(k, 0);
        band_m[0] = 1000;
        for (int k = 1; k < NB; k++) band_m[k] = int'($urandom_range(0, 2000)) - 1000;
        run_sample("weighted", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("weighted.value", $signed(m_if.audio_out), 2000);
        run_sample("midwrite", 0, 0, 0, 0, 0, 1, 0, 16);
        chk("midwrite.value", $signed(m_if.audio_out), 2000);
        run_sample("after_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_mid.value", $signed(m_if.audio_out), 500);

        // Saturation in both directions, then clear
        for (int k = 0; k < NB; k++) write_gain(k, 127);
        for (int k = 0; k < NB; k++) band_m[k] = 8388607;
        run_sample("sat_pos", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_pos.flag", m_if.sat_flag, 1);
        for (int k = 0; k < NB; k++) band_m[k] = -8388608;
        run_sample("sat_neg", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_neg.value", $signed(m_if.audio_out), -8388608);
        @(negedge clk);
        m_if.sat_clr = 1'b1;
        @(negedge clk);
        m_if.sat_clr = 1'b0;
        sat_m = 1'b0;
        chk("sat_clr.flag", m_if.sat_flag, 0);

        // Bypass with in_valid held high: one accept every 11 cycles, nothing lost
        @(negedge clk);
        m_if.in_valid = 1'b1;
        m_if.bypass   = 1'b1;
        m_if.audio_in = 24'd12345;
        will_acc = m_if.in_valid && m_if.in_ready;
        n_acc = 0; n_out = 0; last_acc = 0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            if (will_acc) begin
                if (n_acc > 0) chk("bp.spacing", i - last_acc, 11);
                exp_q.push_back(int'(m_if.audio_in));
                t_q.push_back(i);
                last_acc = i;
                n_acc++;
                m_if.audio_in = m_if.audio_in + 24'd7;
            end
            if (m_if.out_valid) begin
                n_out++;
                chk("bp.pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("bp.audio_out", $signed(m_if.audio_out), exp_q.pop_front());
                    chk("bp.latency", i - t_q.pop_front(), 10);
                end
            end
            if (i == 45) m_if.in_valid = 1'b0;
            will_acc = m_if.in_valid && m_if.in_ready;
        end
        m_if.bypass = 1'b0;
        chk("bp.accepts", n_acc, 5);
        chk("bp.outputs", n_out, 5);
        chk("bp.sat_flag", m_if.sat_flag, 0);

        // Randomized samples, gain writes (some out of range), bypass and same-cycle writes
        for (int r = 0; r < 12; r++) begin
            cnt = int'($urandom_range(0, 3));
            for (int w = 0; w < cnt; w++) begin
                write_gain(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
            end
            for (int k = 0; k < NB; k++) begin
                if (r[0]) band_m[k] = int'($urandom) >>> 8;
                else      band_m[k] = int'($urandom_range(0, 131071)) - 65536;
            end
            run_sample("rand", ($urandom_range(0, 3) == 0), int'($urandom) >>> 8,
                       bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)) - 128,
                       bit'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 255)) - 128);
        end

        // Reset while MAC is at index 4
        write_gain(3, 5);
        for (int k = 0; k < NB; k++) band_m[k] = int'($urandom_range(1, 20000));
        @(negedge clk);
        m_if.in_valid = 1'b1;
        for (int k = 0; k < NB; k++) m_if.bands_in[k*AW +: AW] = 24'(band_m[k]);
        @(negedge clk);
        m_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", m_if.out_valid, 0);
        chk("midrst.audio_out", m_if.audio_out, 0);
        chk("midrst.in_ready", m_if.in_ready, 1);
        chk("midrst.sat_flag", m_if.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NB; k++) pend_m[k] = 32;
        sat_m = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_if.out_valid) cnt++;
        end
        chk("midrst.no_strobe", cnt, 0);
        chk("midrst.ready_after", m_if.in_ready, 1);
        run_sample("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        expv = 0;
        for (int k = 0; k < NB; k++) expv += band_m[k];
        chk("post_rst.sum", $signed(m_if.audio_out), expv);

        // Three-band instance with integer gains
        sg[0] = 1; sg[1] = -2; sg[2] = 3;
        sb[0] = 100; sb[1] = 200; sb[2] = 300;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_if.gain_we    = 1'b1;
            s_if.gain_addr  = 2'(k);
            s_if.gain_wdata = 8'(sg[k]);
            @(negedge clk);
            s_if.gain_we = 1'b0;
        end
        expv = 0;
        for (int k = 0; k < 3; k++) expv += sb[k] * sg[k];
        @(negedge clk);
        s_if.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) s_if.bands_in[k*AW +: AW] = 24'(sb[k]);
        t0 = 0;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        lat = t0;
        while (!s_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("small.latency", lat, 3);
        chk("small.audio_out", $signed(s_if.audio_out), expv);
        chk("small.value", $signed(s_if.audio_out), 600);
        chk("small.sat_flag", s_if.sat_flag, 0);
        @(negedge clk);
        chk("small.pulse", s_if.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
